pipe_stage_regs: RTL and testbench

//  Fetch PC register plus IF/ID and ID/EX pipeline registers of the 5-stage in-order core.

---
 rtl/pipe_stage_regs.sv | 142 ++++++++++++++
 tb/tb_pipe_stage_regs.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_regs.sv
`default_nettype none
//============================================================================
// Module   : pipe_stage_regs
// Purpose  : Fetch PC, IF/ID and ID/EX pipeline registers with stall, flush
//            and redirect handling. Optional macro PIPE_PERF_EN adds
//            stall/flush event counters.
// Revision : 1.0  initial release
//============================================================================
module pipe_stage_regs #(
    parameter int                 XLEN      = 32,
    parameter int                 CTRL_W    = 16,
    parameter logic [XLEN-1:0]    RESET_PC  = '0,
    parameter logic [31:0]        NOP_INSTR = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stallf,
    input  logic                  stalld,
    input  logic                  flushd,
    input  logic                  flushe,
    input  logic                  pcSrce,
    input  logic [XLEN-1:0]       pcTargete,
    input  logic [31:0]           instrf,
    output logic [XLEN-1:0]       pcf,
    output logic [31:0]           instrd,
    output logic [XLEN-1:0]       pcd,
    output logic [XLEN-1:0]       pcplus4d,
    output logic                  validd,
    input  logic [4:0]            rs1d,
    input  logic [4:0]            rs2d,
    input  logic [4:0]            rdd,
    input  logic [XLEN-1:0]       rd1d,
    input  logic [XLEN-1:0]       rd2d,
    input  logic [XLEN-1:0]       immextd,
    input  logic [CTRL_W-1:0]     ctrld,
    output logic [4:0]            rs1e,
    output logic [4:0]            rs2e,
    output logic [4:0]            rde,
    output logic [XLEN-1:0]       rd1e,
    output logic [XLEN-1:0]       rd2e,
    output logic [XLEN-1:0]       immexte,
    output logic [XLEN-1:0]       pce,
    output logic [XLEN-1:0]       pcplus4e,
    output logic [CTRL_W-1:0]     ctrle,
    output logic                  valide
`ifdef PIPE_PERF_EN
    ,
    output logic [31:0]           stall_cnt,
    output logic [31:0]           flush_cnt
`endif
);

    logic [XLEN-1:0] pc_plus4;

    assign pc_plus4 = pcf + XLEN'(4);

    // Redirect takes precedence over stall so a resolved branch is never dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcf <= RESET_PC;
        end else if (pcSrce) begin
            pcf <= pcTargete;
        end else if (!stallf) begin
            pcf <= pc_plus4;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instrd   <= NOP_INSTR;
            pcd      <= '0;
            pcplus4d <= '0;
            validd   <= 1'b0;
        end else if (flushd) begin
            instrd   <= NOP_INSTR;
            pcd      <= '0;
            pcplus4d <= '0;
            validd   <= 1'b0;
        end else if (!stalld) begin
            instrd   <= instrf;
            pcd      <= pcf;
            pcplus4d <= pc_plus4;
            validd   <= 1'b1;
        end
    end

    // A bubble zeroes rde so it can never match a forwarding comparison.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs1e     <= '0;
            rs2e     <= '0;
            rde      <= '0;
            rd1e     <= '0;
            rd2e     <= '0;
            immexte  <= '0;
            pce      <= '0;
            pcplus4e <= '0;
            ctrle    <= '0;
            valide   <= 1'b0;
        end else if (flushe) begin
            rs1e     <= '0;
            rs2e     <= '0;
            rde      <= '0;
            rd1e     <= '0;
            rd2e     <= '0;
            immexte  <= '0;
            pce      <= '0;
            pcplus4e <= '0;
            ctrle    <= '0;
            valide   <= 1'b0;
        end else begin
            rs1e     <= rs1d;
            rs2e     <= rs2d;
            rde      <= rdd;
            rd1e     <= rd1d;
            rd2e     <= rd2d;
            immexte  <= immextd;
            pce      <= pcd;
            pcplus4e <= pcplus4d;
            ctrle    <= ctrld;
            valide   <= validd;
        end
    end

`ifdef PIPE_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stalld && !flushd) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (flushe) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_regs.sv
`default_nettype none
//============================================================================
// Module   : tb_pipe_stage_regs
// Purpose  : Self-checking bench for pipe_stage_regs against a stage-level
//            reference model; directed corner cases then random traffic.
// Revision : 1.0  initial release
//============================================================================
module tb_pipe_stage_regs;

    localparam int          XLEN   = 32;
    localparam int          CTRL_W = 16;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst;
    logic stallf, stalld, flushd, flushe, pcSrce;
    logic [XLEN-1:0] pcTargete;
    logic [31:0] instrf;
    logic [XLEN-1:0] pcf, pcd, pcplus4d;
    logic [31:0] instrd;
    logic validd;
    logic [4:0] rs1d, rs2d, rdd, rs1e, rs2e, rde;
    logic [XLEN-1:0] rd1d, rd2d, immextd, rd1e, rd2e, immexte, pce, pcplus4e;
    logic [CTRL_W-1:0] ctrld, ctrle;
    logic valide;
`ifdef PIPE_PERF_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    pipe_stage_regs #(
        .XLEN(XLEN), .CTRL_W(CTRL_W), .RESET_PC(32'h0), .NOP_INSTR(NOP)
    ) dut (
        .clk(clk), .rst(rst), .stallf(stallf), .stalld(stalld),
        .flushd(flushd), .flushe(flushe), .pcSrce(pcSrce), .pcTargete(pcTargete),
        .instrf(instrf), .pcf(pcf), .instrd(instrd), .pcd(pcd),
        .pcplus4d(pcplus4d), .validd(validd),
        .rs1d(rs1d), .rs2d(rs2d), .rdd(rdd), .rd1d(rd1d), .rd2d(rd2d),
        .immextd(immextd), .ctrld(ctrld),
        .rs1e(rs1e), .rs2e(rs2e), .rde(rde), .rd1e(rd1e), .rd2e(rd2e),
        .immexte(immexte), .pce(pce), .pcplus4e(pcplus4e), .ctrle(ctrle),
        .valide(valide)
`ifdef PIPE_PERF_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: one record per pipeline stage.
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        valid;
    } d_stage_t;

    typedef struct {
        logic [4:0]        rs1, rs2, rd;
        logic [31:0]       rd1, rd2, imm, pc, pc4;
        logic [CTRL_W-1:0] ctrl;
        logic              valid;
    } e_stage_t;

    logic [31:0] m_pc;
    d_stage_t    m_d;
    e_stage_t    m_e;
    int unsigned m_stalls, m_flushes;

    int errors = 0;
    int checks = 0;

    function automatic d_stage_t d_bubble();
        d_stage_t b;
        b.instr = NOP; b.pc = '0; b.pc4 = '0; b.valid = 1'b0;
        return b;
    endfunction

    function automatic e_stage_t e_bubble();
        e_stage_t b;
        b.rs1 = '0; b.rs2 = '0; b.rd = '0; b.rd1 = '0; b.rd2 = '0;
        b.imm = '0; b.pc = '0; b.pc4 = '0; b.ctrl = '0; b.valid = 1'b0;
        return b;
    endfunction

    task automatic model_reset();
        m_pc = 32'h0;
        m_d  = d_bubble();
        m_e  = e_bubble();
        m_stalls = 0;
        m_flushes = 0;
    endtask

    // Advance the model by one clock using the inputs presented before the edge.
    task automatic model_step();
        logic [31:0] nxt_pc;
        d_stage_t    nxt_d, fetched;
        e_stage_t    nxt_e, decoded;
        fetched.instr = instrf; fetched.pc = m_pc;
        fetched.pc4 = m_pc + 32'd4; fetched.valid = 1'b1;
        decoded.rs1 = rs1d; decoded.rs2 = rs2d; decoded.rd = rdd;
        decoded.rd1 = rd1d; decoded.rd2 = rd2d; decoded.imm = immextd;
        decoded.pc = m_d.pc; decoded.pc4 = m_d.pc4; decoded.ctrl = ctrld;
        decoded.valid = m_d.valid;
        nxt_pc = pcSrce ? pcTargete : (stallf ? m_pc : m_pc + 32'd4);
        nxt_d  = flushd ? d_bubble() : (stalld ? m_d : fetched);
        nxt_e  = flushe ? e_bubble() : decoded;
        if (stalld && !flushd) m_stalls++;
        if (flushe) m_flushes++;
        m_pc = nxt_pc; m_d = nxt_d; m_e = nxt_e;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".pcf"},      64'(pcf),      64'(m_pc));
        chk({tag, ".instrd"},   64'(instrd),   64'(m_d.instr));
        chk({tag, ".pcd"},      64'(pcd),      64'(m_d.pc));
        chk({tag, ".pcplus4d"}, 64'(pcplus4d), 64'(m_d.pc4));
        chk({tag, ".validd"},   64'(validd),   64'(m_d.valid));
        chk({tag, ".rs1e"},     64'(rs1e),     64'(m_e.rs1));
        chk({tag, ".rs2e"},     64'(rs2e),     64'(m_e.rs2));
        chk({tag, ".rde"},      64'(rde),      64'(m_e.rd));
        chk({tag, ".rd1e"},     64'(rd1e),     64'(m_e.rd1));
        chk({tag, ".rd2e"},     64'(rd2e),     64'(m_e.rd2));
        chk({tag, ".immexte"},  64'(immexte),  64'(m_e.imm));
        chk({tag, ".pce"},      64'(pce),      64'(m_e.pc));
        chk({tag, ".pcplus4e"}, 64'(pcplus4e), 64'(m_e.pc4));
        chk({tag, ".ctrle"},    64'(ctrle),    64'(m_e.ctrl));
        chk({tag, ".valide"},   64'(valide),   64'(m_e.valid));
`ifdef PIPE_PERF_EN
        chk({tag, ".stall_cnt"}, 64'(stall_cnt), 64'(m_stalls));
        chk({tag, ".flush_cnt"}, 64'(flush_cnt), 64'(m_flushes));
`endif
    endtask

    task automatic rand_d();
        rs1d = 5'($urandom); rs2d = 5'($urandom); rdd = 5'($urandom);
        rd1d = $urandom; rd2d = $urandom; immextd = $urandom;
        ctrld = CTRL_W'($urandom);
    endtask

    task automatic set_ctrl(input logic sf, input logic sd, input logic fd,
                            input logic fe, input logic ps, input logic [31:0] tgt);
        stallf = sf; stalld = sd; flushd = fd; flushe = fe;
        pcSrce = ps; pcTargete = tgt;
        rand_d();
    endtask

    task automatic cycle(input string tag);
        model_step();
        @(posedge clk);
        #1;
        chk_all(tag);
    endtask

    initial begin
        rst = 1'b1;
        instrf = 32'h0050_0093;
        set_ctrl(0, 0, 0, 0, 0, 32'h0);
        model_reset();
        #1;
        chk_all("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_all("reset_release");
        chk("first_pc", 64'(pcf), 64'h0);

        for (int i = 0; i < 3; i++) begin
            set_ctrl(0, 0, 0, 0, 0, 32'h0);
            cycle("idle");
        end
        chk("idle_pc_c", 64'(pcf), 64'hC);
        chk("idle_instrd", 64'(instrd), 64'h0050_0093);
        chk("idle_validd", 64'(validd), 64'h1);

        set_ctrl(1, 1, 0, 1, 0, 32'h0);
        cycle("load_use");
        chk("lu_pc_hold", 64'(pcf), 64'hC);
        chk("lu_rde", 64'(rde), 64'h0);
        chk("lu_valide", 64'(valide), 64'h0);
        set_ctrl(0, 0, 0, 0, 0, 32'h0);
        cycle("lu_resume");
        chk("lu_advance", 64'(pcf), 64'h10);

        set_ctrl(0, 0, 1, 1, 1, 32'h100);
        cycle("branch");
        chk("br_pc", 64'(pcf), 64'h100);
        chk("br_instrd", 64'(instrd), 64'(NOP));
        chk("br_validd", 64'(validd), 64'h0);
        set_ctrl(0, 0, 0, 0, 0, 32'h0);
        cycle("br_next");
        chk("br_pc_next", 64'(pcf), 64'h104);

        set_ctrl(1, 1, 1, 0, 1, 32'h200);
        cycle("redirect_over_stall");
        chk("rds_pc", 64'(pcf), 64'h200);
        chk("fls_instrd", 64'(instrd), 64'(NOP));

        set_ctrl(0, 0, 0, 0, 1, 32'hFFFF_FFFC);
        cycle("to_top");
        set_ctrl(0, 0, 0, 0, 0, 32'h0);
        cycle("wrap");
        chk("wrap_pc", 64'(pcf), 64'h0);

        set_ctrl(1, 0, 0, 0, 0, 32'h0);
        cycle("stallf_only");
        set_ctrl(0, 1, 0, 0, 0, 32'h0);
        cycle("stalld_only");

        set_ctrl(1, 1, 0, 0, 0, 32'h0);
        #1;
        rst = 1'b1;
        #1;
        model_reset();
        chk_all("rst_async");
        @(posedge clk);
        #1;
        chk_all("rst_held");
        rst = 1'b0;

        for (int i = 0; i < 300; i++) begin
            instrf = $urandom;
            set_ctrl(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                     ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
                     ($urandom_range(0, 5) == 0), {$urandom} & 32'hFFFF_FFFC);
            cycle("random");
        end

`ifdef PIPE_PERF_EN
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_ctrl(1, 1, 0, 1, 0, 32'h0);
            cycle("perf_lu");
            set_ctrl(0, 0, 0, 0, 0, 32'h0);
            cycle("perf_gap");
        end
        for (int i = 0; i < 2; i++) begin
            set_ctrl(0, 0, 1, 1, 1, 32'h40);
            cycle("perf_br");
        end
        chk("perf_stall_cnt", 64'(stall_cnt), 64'd3);
        chk("perf_flush_cnt", 64'(flush_cnt), 64'd5);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
